// File: rtl/le_ctrl_pkg.sv
// Shared encodings for the bit-serial logic-unit controller and its per-bit element.
// The state and op constants are shared by le1 and le_serial_ctrl.
package le_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [2:0] OP_NOTA  = 3'b000;
   localparam logic [2:0] OP_AND   = 3'b001;
   localparam logic [2:0] OP_PASSA = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   // Only bit 2 (m) is significant; s is don't-care when m=1.
   localparam logic [2:0] OP_PASS  = 3'b100;

endpackage

// File: rtl/le1.sv
// Single-bit logic element: x = f(a, b) selected by mode bit m and select s.
module le1
   import le_ctrl_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       m,
   input  logic [1:0] s,
   output logic       x
);

   always_comb begin
      x = a;
      if (m == OP_PASS[2]) begin
         x = a;
      end else begin
         case ({m, s})
            OP_NOTA:  x = ~a;
            OP_AND:   x = a & b;
            OP_PASSA: x = a;
            OP_OR:    x = a | b;
            default:  x = a;
         endcase
      end
   end

endmodule

// File: rtl/le_serial_ctrl.sv
// Bit-serial logic-unit controller: runs le1 over WIDTH bits, LSB first, one bit per clock.
// Optional zero flag enabled by defining LE_SERIAL_ZFLAG_EN; otherwise zero is tied low.
module le_serial_ctrl
   import le_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, result_q;
   logic [2:0]       op_q;
   logic             busy_q, done_q;
   logic             x;
   logic             accept, last_bit;
   logic [WIDTH-1:0] res_next;

   assign accept   = (state_q == IDLE) && start;
   assign last_bit = (state_q == SHIFT) && (cnt_q == CntLast);
   assign res_next = {x, res_sr_q[WIDTH-1:1]};

   le1 u_le1 (
      .a (a_sr_q[0]),
      .b (b_sr_q[0]),
      .m (op_q[2]),
      .s (op_q[1:0]),
      .x (x)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == CntLast) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         op_q     <= '0;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         if (accept) begin
            a_sr_q <= a_in;
            b_sr_q <= b_in;
            op_q   <= op;
            cnt_q  <= '0;
         end else if (state_q == SHIFT) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= res_next;
            // Hold on the final bit so the counter never wraps within a run.
            if (!last_bit) cnt_q <= cnt_q + CW'(1);
            // Publish at the edge entering DONE so result is valid alongside done.
            if (last_bit) result_q <= res_next;
         end
      end
   end

`ifdef LE_SERIAL_ZFLAG_EN
   logic acc_q, zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         if (accept) begin
            acc_q <= 1'b0;
         end else if (state_q == SHIFT) begin
            acc_q <= acc_q | x;
            if (last_bit) zero_q <= ~(acc_q | x);
         end
      end
   end

   assign zero = zero_q;
`else
   assign zero = 1'b0;
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_le_serial_ctrl.sv
// Self-checking bench for le_serial_ctrl (WIDTH=8) with a result scoreboard.
module tb_le_serial_ctrl;
   import le_ctrl_pkg::*;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         busy, done, zero;
   logic [W-1:0] result;

   le_serial_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
   } exp_t;

   exp_t         sb[$];
   exp_t         exp_e;
   logic [W-1:0] held = '0;
   int           n_tests = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           lat;
   int           acc_cyc[3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         if (o[2]) r[i] = a[i];
         else begin
            case (o[1:0])
               2'b00:   r[i] = ~a[i];
               2'b01:   r[i] = a[i] & b[i];
               2'b10:   r[i] = a[i];
               default: r[i] = a[i] | b[i];
            endcase
         end
      end
      return r;
   endfunction

   function automatic exp_t mk(input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
      exp_t e;
      e.res = model(o, a, b);
`ifdef LE_SERIAL_ZFLAG_EN
      e.z = (e.res == '0);
`else
      e.z = 1'b0;
`endif
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: each done pulse pops one expectation; between pulses result must hold.
   always @(negedge clk) begin
      if (rst) begin
         held = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            check_eq("spurious_done", done, 0);
         end else begin
            exp_e = sb.pop_front();
            check_eq("result", result, exp_e.res);
            check_eq("zero", zero, exp_e.z);
            held = exp_e.res;
         end
      end else begin
         check_eq("result_held", result, held);
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 40);
      if (!done) check_eq("done_timeout", done, 1);
   endtask

   task automatic wait_busy(input logic lvl);
      int n = 0;
      while (busy !== lvl && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy !== lvl) check_eq("busy_timeout", busy, lvl);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int l);
      @(negedge clk);
      op = o; a_in = a; b_in = b; start = 1'b1;
      sb.push_back(mk(o, a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in = ~a; b_in = ~b; op = ~o;
      check_eq("busy_after_accept", busy, 1);
      wait_done(l);
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_idle", busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_zero", zero, 0);
      rst = 1'b0;

      // done is high in cycle k+WIDTH+1, i.e. WIDTH edges after the accept edge.
      run_op(OP_AND, 8'hF0, 8'h3C, lat);
      check_eq("latency", lat, W);
      run_op(OP_NOTA, 8'h5A, 8'hFF, lat);
      run_op(OP_OR, 8'h81, 8'h18, lat);
      for (int s = 0; s < 4; s++) begin
         run_op({1'b1, 2'(s)}, 8'h7E, 8'($urandom), lat);
      end
      for (int i = 0; i < 4; i++) begin
         run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), lat);
      end

      // start pulses mid-run and during DONE must be ignored.
      @(negedge clk);
      op = OP_AND; a_in = 8'h0F; b_in = 8'hF0; start = 1'b1;
      sb.push_back(mk(OP_AND, 8'h0F, 8'hF0));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      op = OP_OR; a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      op = OP_NOTA; a_in = 8'h00; b_in = 8'h00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("no_restart", busy, 0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("still_idle", busy, 0);

      // Reset in cycle k+4 of an OR run discards it.
      @(negedge clk);
      op = OP_OR; a_in = 8'h81; b_in = 8'h18; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_result", result, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_eq("post_rst_idle", busy, 0);
      run_op(OP_AND, 8'hFF, 8'hAA, lat);

      // Back-to-back with start held high: accepts exactly WIDTH+2 cycles apart.
      @(negedge clk);
      op = OP_OR; a_in = 8'h12; b_in = 8'h40; start = 1'b1;
      sb.push_back(mk(OP_OR, 8'h12, 8'h40));
      for (int r = 0; r < 3; r++) begin
         wait_busy(1'b1);
         acc_cyc[r] = cyc;
         if (r == 0) begin
            op = OP_AND; a_in = 8'hC3; b_in = 8'h0F;
            sb.push_back(mk(OP_AND, 8'hC3, 8'h0F));
         end else if (r == 1) begin
            op = OP_NOTA; a_in = 8'hFF; b_in = 8'h00;
            sb.push_back(mk(OP_NOTA, 8'hFF, 8'h00));
         end else begin
            start = 1'b0;
         end
         wait_busy(1'b0);
      end
      check_eq("spacing_0_1", acc_cyc[1] - acc_cyc[0], W + 2);
      check_eq("spacing_1_2", acc_cyc[2] - acc_cyc[1], W + 2);

      repeat (4) @(posedge clk);
      #1;
      check_eq("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
